// File: rtl/proc_pkg.sv
// Shared definitions for the processor control FSM: state encoding,
// instruction field layout and opcode constants.
package proc_pkg;

    typedef enum logic [1:0] {
        StT0 = 2'd0,
        StT1 = 2'd1,
        StT2 = 2'd2,
        StT3 = 2'd3
    } state_e;

    typedef struct packed {
        logic [2:0] op;
        logic [2:0] rx;
        logic [2:0] ry;
    } ir_t;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    // Add and sub are the only multi-cycle instructions.
    function automatic logic is_alu(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/dec3to8.sv
// 3-bit index to 8-bit one-hot decoder with enable; all zeros when disabled.
module dec3to8 (
    input  logic       en_i,
    input  logic [2:0] idx_i,
    output logic [7:0] onehot_o
);

    always_comb begin
        onehot_o = 8'h00;
        if (en_i) begin
            onehot_o[idx_i] = 1'b1;
        end
    end

endmodule

// File: rtl/proc_control.sv
// Control FSM for a simple bus-based processor: decodes the captured
// instruction into register, ALU and bus-drive enables, one state per cycle.
module proc_control
    import proc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [8:0] instr,
    output logic [7:0] r_in,
    output logic [7:0] r_out,
    output logic       a_in,
    output logic       g_in,
    output logic       g_out,
    output logic       din_out,
    output logic       addsub,
    output logic       done
);

    state_e state_q, state_d;
    ir_t    ir_q, ir_d;

    logic [7:0] x_oh;
    logic [7:0] y_oh;

    // Decoders are disabled during reset so no enable can leak out.
    dec3to8 u_dec_x (
        .en_i     (rst),
        .idx_i    (ir_q.rx),
        .onehot_o (x_oh)
    );

    dec3to8 u_dec_y (
        .en_i     (rst),
        .idx_i    (ir_q.ry),
        .onehot_o (y_oh)
    );

    always_ff @(posedge clk) begin
        state_q <= state_d;
        ir_q    <= ir_d;
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        unique case (state_q)
            StT0: begin
                if (run) begin
                    ir_d    = ir_t'(instr);
                    state_d = StT1;
                end
            end
            StT1:    state_d = is_alu(ir_q.op) ? StT2 : StT0;
            StT2:    state_d = StT3;
            StT3:    state_d = StT0;
            default: state_d = StT0;
        endcase
        if (!rst) begin
            state_d = StT0;
            ir_d    = '0;
        end
    end

    always_comb begin
        r_in    = 8'h00;
        r_out   = 8'h00;
        a_in    = 1'b0;
        g_in    = 1'b0;
        g_out   = 1'b0;
        din_out = 1'b0;
        addsub  = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            StT0: ;
            StT1: begin
                case (ir_q.op)
                    OP_MV: begin
                        r_out = y_oh;
                        r_in  = x_oh;
                        done  = 1'b1;
                    end
                    OP_MVI: begin
                        din_out = 1'b1;
                        r_in    = x_oh;
                        done    = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        r_out = x_oh;
                        a_in  = 1'b1;
                    end
                    default: done = 1'b1;
                endcase
            end
            StT2: begin
                r_out  = y_oh;
                g_in   = 1'b1;
                addsub = ir_q.op[0];
            end
            StT3: begin
                g_out = 1'b1;
                r_in  = x_oh;
                done  = 1'b1;
            end
            default: ;
        endcase
        if (!rst) begin
            r_in    = 8'h00;
            r_out   = 8'h00;
            a_in    = 1'b0;
            g_in    = 1'b0;
            g_out   = 1'b0;
            din_out = 1'b0;
            addsub  = 1'b0;
            done    = 1'b0;
        end
    end

endmodule

// File: tb/tb_proc_control.sv
// Directed bench for proc_control; outputs packed as
// {r_in, r_out, a_in, g_in, g_out, din_out, addsub, done}.
module tb_proc_control;

    logic       clk;
    logic       rst;
    logic       run;
    logic [8:0] instr;
    logic [7:0] r_in;
    logic [7:0] r_out;
    logic       a_in;
    logic       g_in;
    logic       g_out;
    logic       din_out;
    logic       addsub;
    logic       done;

    logic [21:0] obs;
    logic [21:0] exp_v;
    int          checks;
    int          errors;
    bit          inv_on;

    assign obs = {r_in, r_out, a_in, g_in, g_out, din_out, addsub, done};

    proc_control dut (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .instr   (instr),
        .r_in    (r_in),
        .r_out   (r_out),
        .a_in    (a_in),
        .g_in    (g_in),
        .g_out   (g_out),
        .din_out (din_out),
        .addsub  (addsub),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Invariants checked every cycle while the random stream runs.
    always @(negedge clk) begin
        if (inv_on) begin
            checks++;
            if ($countones({r_out, g_out, din_out}) > 1) begin
                errors++;
                $display("FAIL bus_driver drivers=%b required at most one", {r_out, g_out, din_out});
            end
            checks++;
            if ($countones(r_in) > 1) begin
                errors++;
                $display("FAIL r_in_onehot r_in=%h required at most one bit", r_in);
            end
            checks++;
            if (addsub && !g_in) begin
                errors++;
                $display("FAIL addsub_t2 addsub=%b g_in=%b required addsub only in T2", addsub, g_in);
            end
        end
    end

    task automatic test_reset();
        rst = 1'b0; run = 1'b1; instr = 9'b010_001_010;
        tick();
        checks++;
        if (obs !== 22'h0) begin
            errors++; $display("FAIL reset_held obs=%h required=%h", obs, 22'h0);
        end
        tick();
        rst = 1'b1; run = 1'b0;
        #1;
        checks++;
        if (obs !== 22'h0) begin
            errors++; $display("FAIL reset_t0 obs=%h required=%h", obs, 22'h0);
        end
        tick();
        checks++;
        if (obs !== 22'h0) begin
            errors++; $display("FAIL idle_no_run obs=%h required=%h", obs, 22'h0);
        end
    endtask

    task automatic test_mv();
        run = 1'b1; instr = 9'b000_010_101;
        tick();
        run = 1'b0;
        exp_v = {8'h04, 8'h20, 6'b000001};
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL mv_t1 obs=%h required=%h", obs, exp_v);
        end
        tick();
        checks++;
        if (obs !== 22'h0) begin
            errors++; $display("FAIL mv_back_t0 obs=%h required=%h", obs, 22'h0);
        end
    endtask

    task automatic test_mvi();
        run = 1'b1; instr = 9'b001_111_000;
        tick();
        run = 1'b0;
        exp_v = {8'h80, 8'h00, 6'b000101};
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL mvi_t1 obs=%h required=%h", obs, exp_v);
        end
        tick();
        checks++;
        if (obs !== 22'h0) begin
            errors++; $display("FAIL mvi_back_t0 obs=%h required=%h", obs, 22'h0);
        end
    endtask

    task automatic test_sub();
        run = 1'b1; instr = 9'b011_001_100;
        tick();
        run = 1'b0;
        exp_v = {8'h00, 8'h02, 6'b100000};
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL sub_t1 obs=%h required=%h", obs, exp_v);
        end
        tick();
        exp_v = {8'h00, 8'h10, 6'b010010};
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL sub_t2 obs=%h required=%h", obs, exp_v);
        end
        tick();
        exp_v = {8'h02, 8'h00, 6'b001001};
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL sub_t3 obs=%h required=%h", obs, exp_v);
        end
        tick();
        checks++;
        if (obs !== 22'h0) begin
            errors++; $display("FAIL sub_back_t0 obs=%h required=%h", obs, 22'h0);
        end
    endtask

    task automatic test_back_to_back();
        run = 1'b1; instr = 9'b010_011_011;
        tick();
        exp_v = {8'h00, 8'h08, 6'b100000};
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL b2b_add_t1 obs=%h required=%h", obs, exp_v);
        end
        instr = 9'b111_111_111;
        tick();
        exp_v = {8'h00, 8'h08, 6'b010000};
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL b2b_add_t2 obs=%h required=%h", obs, exp_v);
        end
        tick();
        exp_v = {8'h08, 8'h00, 6'b001001};
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL b2b_add_t3 obs=%h required=%h", obs, exp_v);
        end
        instr = 9'b000_110_001;
        tick();
        checks++;
        if (obs !== 22'h0) begin
            errors++; $display("FAIL b2b_t0 obs=%h required=%h", obs, 22'h0);
        end
        tick();
        run = 1'b0;
        exp_v = {8'h40, 8'h02, 6'b000001};
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL b2b_mv_t1 obs=%h required=%h", obs, exp_v);
        end
        tick();
        checks++;
        if (obs !== 22'h0) begin
            errors++; $display("FAIL b2b_end_t0 obs=%h required=%h", obs, 22'h0);
        end
    endtask

    task automatic test_nop();
        run = 1'b1; instr = 9'b110_101_010;
        tick();
        run = 1'b0;
        exp_v = {8'h00, 8'h00, 6'b000001};
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL nop_t1 obs=%h required=%h", obs, exp_v);
        end
        tick();
        checks++;
        if (obs !== 22'h0) begin
            errors++; $display("FAIL nop_back_t0 obs=%h required=%h", obs, 22'h0);
        end
    endtask

    task automatic test_reset_mid();
        run = 1'b1; instr = 9'b010_000_111;
        tick();
        run = 1'b0;
        tick();
        exp_v = {8'h00, 8'h80, 6'b010000};
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL rmid_t2 obs=%h required=%h", obs, exp_v);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (obs !== 22'h0) begin
            errors++; $display("FAIL rmid_forced obs=%h required=%h", obs, 22'h0);
        end
        tick();
        checks++;
        if (obs !== 22'h0) begin
            errors++; $display("FAIL rmid_cycle1 obs=%h required=%h", obs, 22'h0);
        end
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== 22'h0) begin
            errors++; $display("FAIL rmid_released obs=%h required=%h", obs, 22'h0);
        end
        tick();
        checks++;
        if (obs !== 22'h0) begin
            errors++; $display("FAIL rmid_no_done obs=%h required=%h", obs, 22'h0);
        end
    endtask

    task automatic test_random_stream();
        inv_on = 1'b1;
        for (int i = 0; i < 300; i++) begin
            run   = 1'($urandom);
            instr = 9'($urandom);
            tick();
        end
        inv_on = 1'b0;
        run = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        inv_on = 1'b0;
        rst    = 1'b0;
        run    = 1'b0;
        instr  = 9'h0;
        test_reset();
        test_mv();
        test_mvi();
        test_sub();
        test_back_to_back();
        test_nop();
        test_reset_mid();
        test_random_stream();
        test_nop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/proc_control.md
PROC_CONTROL -- requirements
Module: proc_control

Interface
REQ-001 The block SHALL expose clk  input  1  single system clock; all state changes on its rising edge.
REQ-002 The block SHALL expose rst  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-003 The block SHALL expose run  input  1  start request, sampled only in state T0.
REQ-004 The block SHALL expose instr  input  9  instruction word: [8:6] opcode, [5:3] X register, [2:0] Y register.
REQ-005 The block SHALL expose r_in  output  8  one-hot load enables for bus registers R0..R7.
REQ-006 The block SHALL expose r_out  output  8  one-hot bus-drive enables for R0..R7.
REQ-007 The block SHALL expose a_in  output  1  load enable for ALU operand register A.
REQ-008 The block SHALL expose g_in  output  1  load enable for ALU result register G.
REQ-009 The block SHALL expose g_out  output  1  bus-drive enable for G.
REQ-010 The block SHALL expose din_out  output  1  bus-drive enable for external data input.
REQ-011 The block SHALL expose addsub  output  1  ALU op select: 0 add, 1 subtract.
REQ-012 The block SHALL expose done  output  1  one-cycle pulse in the final cycle of each instruction.

Function
REQ-013 The block SHALL implement a four-state FSM T0 (idle/fetch), T1, T2, T3.
REQ-014 In T0 with run=1, the block SHALL capture instr into an internal 9-bit IR and go to T1; with run=0 it SHALL stay in T0; run SHALL be ignored in T1-T3.
REQ-015 In T0 all enable outputs, addsub and done SHALL be 0.
REQ-016 Opcode 000 (mv): T1 asserts r_out[Y], r_in[X], done; next state T0.
REQ-017 Opcode 001 (mvi): T1 asserts din_out, r_in[X], done; next state T0.
REQ-018 Opcodes 010 (add) and 011 (sub): T1 asserts r_out[X], a_in -> T2; T2 asserts r_out[Y], g_in, addsub=opcode[0] -> T3; T3 asserts g_out, r_in[X], done -> T0.
REQ-019 Opcodes 100-111 SHALL act as NOP: T1 asserts done only; next state T0.
REQ-020 Outputs SHALL be combinational decodes of the current state and IR (Moore); no output depends on run or instr directly.
REQ-021 At most one of r_out[7:0], g_out, din_out SHALL be 1 in any cycle (single bus driver).
REQ-022 At most one r_in bit SHALL be 1 in any cycle; addsub SHALL be 0 in every state other than T2.
REQ-023 X==Y SHALL need no special handling (add R3,R3 doubles R3).
REQ-024 Latency from T0 capture: mv/mvi/NOP 1 cycle, add/sub 3 cycles; back-to-back instructions SHALL be accepted in the T0 cycle immediately after done.

Reset
REQ-025 When rst=0 at a rising edge, the FSM SHALL enter T0 and IR SHALL clear to 0, regardless of current state.
REQ-026 While rst=0, all outputs SHALL be 0 (combinationally forced).
REQ-027 Reset mid-instruction SHALL abort it: no done pulse and no r_in assertion after the reset edge.

Structure
REQ-028 A shared package proc_pkg SHALL hold opcode constants (OP_MV, OP_MVI, OP_ADD, OP_SUB) and the state encoding typedef.
REQ-029 A sub-module dec3to8 (3-bit index to 8-bit one-hot, with enable) SHALL be instantiated for the X and Y selects.

Verification
REQ-030 Scenario: rst=0 for 2 cycles in T2 of an add -> next cycle in T0, all outputs 0, no done.
REQ-031 Scenario: run=1, instr=9'b000_010_101 (mv R2,R5) -> T1: r_out=8'h20, r_in=8'h04, done=1; then T0.
REQ-032 Scenario: instr=9'b001_111_000 (mvi R7) -> T1: din_out=1, r_in=8'h80, done=1.
REQ-033 Scenario: instr=9'b011_001_100 (sub R1,R4) -> T1 r_out=8'h02,a_in; T2 r_out=8'h10,g_in,addsub=1; T3 g_out,r_in=8'h02,done.
REQ-034 Scenario: run held high across add then mv -> second instr captured in T0 right after done; instr changing during T1-T3 has no effect.
REQ-035 Scenario: every cycle of a random instruction stream -> single-bus-driver and one-hot r_in assertions hold; opcode 110 gives done in T1 with no enables.
